scramble_key_sched: RTL and testbench

SCRAMBLE_KEY_SCHED -- requirements
Module: scramble_key_sched

---
 rtl/scramble_key_sched.sv | 235 +++++++++++++++++++++++
 tb/tb_scramble_key_sched.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scramble_key_sched.sv
// -----------------------------------------------------------------------------
// scramble_key_sched
//
// Generates a pair of 8-entry permutations (left and right halves) for an FFT
// sample scrambler. A 16-bit Galois LFSR drives a Fisher-Yates shuffle of each
// pending buffer, one swap per cycle. The pending pair is committed to the
// output keys on a frame_start pulse while READY, and a new pair is generated
// in the background for the following frame.
//
// Optional feature macro: SCRAMBLE_KEY_OVERRUN_CNT_EN
//   defined   -> overrun_count counts frame_start pulses that arrive while
//                not READY, saturating at 8'hFF
//   undefined -> overrun_count is tied to zero, no counter is built
//
// Ports
//   clock          rising-edge clock for all state
//   reset          synchronous active-high reset
//   enable         1 = scrambling active, 0 = bypass (keys forced to zero)
//   frame_start    one-cycle pulse at the first sample of each FFT frame
//   seed_load      one-cycle pulse loading seed into the LFSR
//   seed[15:0]     LFSR seed value (zero is replaced by 16'hACE1)
//   current_key_l  committed left permutation, field k at bits [3k+2:3k]
//   current_key_r  committed right permutation, same packing
//   key_valid      current keys are a committed permutation pair
//   busy           high while a shuffle pass is running (GEN_L or GEN_R)
//   frame_count    number of committed frames, wraps at 16 bits
//   overrun_count  frame_start pulses seen while not READY
// -----------------------------------------------------------------------------
module scramble_key_sched (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [23:0] current_key_l,
    output logic [23:0] current_key_r,
    output logic        key_valid,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [7:0]  overrun_count
);

    localparam logic [23:0] IDENTITY   = 24'hFAC688;
    localparam logic [15:0] LFSR_INIT  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [2:0]  FIRST_STEP = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN_L = 2'd1,
        GEN_R = 2'd2,
        READY = 2'd3
    } state_t;

    state_t      state_q,  state_d;
    logic [15:0] lfsr_q,   lfsr_d;
    logic [2:0]  step_q,   step_d;
    logic [23:0] pend_l_q, pend_l_d;
    logic [23:0] pend_r_q, pend_r_d;
    logic [23:0] key_l_q,  key_l_d;
    logic [23:0] key_r_q,  key_r_d;
    logic        valid_q,  valid_d;
    logic        busy_q,   busy_d;
    logic [15:0] fcnt_q,   fcnt_d;

    // Swap index j = (lfsr[7:0] * (i+1)) >> 8. The product never exceeds
    // 255*8 = 2040, so 11 bits hold it and bits [10:8] are j in 0..i.
    logic [3:0]  span;
    logic [10:0] product;
    logic [2:0]  swap_j;
    logic [15:0] lfsr_adv;

    assign span     = {1'b0, step_q} + 4'd1;
    assign product  = {3'b000, lfsr_q[7:0]} * {7'b0000000, span};
    assign swap_j   = product[10:8];
    assign lfsr_adv = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    function automatic logic [23:0] swap_fields(
        input logic [23:0] v,
        input logic [2:0]  a,
        input logic [2:0]  b
    );
        logic [23:0] r;
        r            = v;
        r[3*a +: 3]  = v[3*b +: 3];
        r[3*b +: 3]  = v[3*a +: 3];
        return r;
    endfunction

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the branches
        // below leaves a signal unassigned; otherwise a latch is inferred.
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        step_d   = step_q;
        pend_l_d = pend_l_q;
        pend_r_d = pend_r_q;
        key_l_d  = key_l_q;
        key_r_d  = key_r_q;
        valid_d  = valid_q;
        fcnt_d   = fcnt_q;

        if (seed_load) begin
            // Reseeding discards whatever pair was in flight or committed;
            // a coincident frame_start is deliberately ignored.
            lfsr_d   = (seed == 16'h0000) ? LFSR_INIT : seed;
            key_l_d  = 24'h000000;
            key_r_d  = 24'h000000;
            valid_d  = 1'b0;
            pend_l_d = IDENTITY;
            pend_r_d = IDENTITY;
            step_d   = FIRST_STEP;
            state_d  = enable ? GEN_L : IDLE;
        end else if (!enable) begin
            // Bypass: keys go to zero, LFSR and frame_count are kept so a
            // re-enable continues the same pseudo-random sequence.
            state_d  = IDLE;
            key_l_d  = 24'h000000;
            key_r_d  = 24'h000000;
            valid_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    pend_l_d = IDENTITY;
                    pend_r_d = IDENTITY;
                    step_d   = FIRST_STEP;
                    state_d  = GEN_L;
                end
                GEN_L: begin
                    pend_l_d = swap_fields(pend_l_q, step_q, swap_j);
                    lfsr_d   = lfsr_adv;
                    if (step_q == 3'd1) begin
                        step_d  = FIRST_STEP;
                        state_d = GEN_R;
                    end else begin
                        step_d  = step_q - 3'd1;
                    end
                end
                GEN_R: begin
                    pend_r_d = swap_fields(pend_r_q, step_q, swap_j);
                    lfsr_d   = lfsr_adv;
                    if (step_q == 3'd1) begin
                        step_d  = FIRST_STEP;
                        state_d = READY;
                    end else begin
                        step_d  = step_q - 3'd1;
                    end
                end
                READY: begin
                    if (frame_start) begin
                        key_l_d  = pend_l_q;
                        key_r_d  = pend_r_q;
                        valid_d  = 1'b1;
                        fcnt_d   = fcnt_q + 16'd1;
                        pend_l_d = IDENTITY;
                        pend_r_d = IDENTITY;
                        step_d   = FIRST_STEP;
                        state_d  = GEN_L;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // busy is registered from the next state so it always equals
        // (state == GEN_L || state == GEN_R) with no decode after the flop.
        busy_d = (state_d == GEN_L) || (state_d == GEN_R);
    end

    always_ff @(posedge clock) begin
        // NOTE: reset is synchronous here, so it lives inside the clocked
        // block and only takes effect on a rising edge; a pass in progress
        // is simply abandoned.
        if (reset) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_INIT;
            step_q   <= FIRST_STEP;
            pend_l_q <= IDENTITY;
            pend_r_q <= IDENTITY;
            key_l_q  <= 24'h000000;
            key_r_q  <= 24'h000000;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            fcnt_q   <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            step_q   <= step_d;
            pend_l_q <= pend_l_d;
            pend_r_q <= pend_r_d;
            key_l_q  <= key_l_d;
            key_r_q  <= key_r_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            fcnt_q   <= fcnt_d;
        end
    end

`ifdef SCRAMBLE_KEY_OVERRUN_CNT_EN
    // A frame_start outside READY is an overrun unless seed_load claims it.
    logic       overrun;
    logic [7:0] ovr_q, ovr_d;

    assign overrun = frame_start && !seed_load && (state_q != READY);

    always_comb begin
        ovr_d = ovr_q;
        if (overrun && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ovr_q <= 8'h00;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign overrun_count = ovr_q;
`else
    assign overrun_count = 8'h00;
`endif

    assign current_key_l = key_l_q;
    assign current_key_r = key_r_q;
    assign key_valid     = valid_q;
    assign busy          = busy_q;
    assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_scramble_key_sched.sv
// -----------------------------------------------------------------------------
// tb_scramble_key_sched
//
// Directed bench for scramble_key_sched. Inputs change and outputs are sampled
// on the falling clock edge. Expected keys come from a behavioural
// Fisher-Yates/LFSR model kept in lock-step with the generation passes the
// DUT is expected to run.
// -----------------------------------------------------------------------------
module tb_scramble_key_sched;

    localparam int FRAMES = 1000;
    // Any period above 15 cycles lets a pass finish before the next frame.
    localparam int PERIOD = 32;

`ifdef SCRAMBLE_KEY_OVERRUN_CNT_EN
    localparam logic [7:0] OVR_STEP = 8'd1;
`else
    localparam logic [7:0] OVR_STEP = 8'd0;
`endif

    logic        clock;
    logic        reset;
    logic        enable;
    logic        frame_start;
    logic        seed_load;
    logic [15:0] seed;
    logic [23:0] current_key_l;
    logic [23:0] current_key_r;
    logic        key_valid;
    logic        busy;
    logic [15:0] frame_count;
    logic [7:0]  overrun_count;

    scramble_key_sched dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .frame_start   (frame_start),
        .seed_load     (seed_load),
        .seed          (seed),
        .current_key_l (current_key_l),
        .current_key_r (current_key_r),
        .key_valid     (key_valid),
        .busy          (busy),
        .frame_count   (frame_count),
        .overrun_count (overrun_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_vec;
    int          n_err;
    logic [15:0] m_lfsr;
    logic [23:0] exp_l, exp_r;
    logic [23:0] first_l, first_r;
    logic [15:0] exp_fc;
    logic [7:0]  exp_ovr;
    int          bad_perm;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic cycle();
        @(negedge clock);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // One full generation: shuffle left then right, 7 swaps each.
    task automatic model_gen(output logic [23:0] l, output logic [23:0] r);
        logic [2:0]  f[8];
        logic [2:0]  t;
        logic [23:0] packed_v[2];
        int          j;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 8; k++) f[k] = 3'(k);
            for (int i = 7; i >= 1; i--) begin
                j      = (int'(m_lfsr[7:0]) * (i + 1)) >> 8;
                t      = f[i];
                f[i]   = f[j];
                f[j]   = t;
                m_lfsr = lfsr_step(m_lfsr);
            end
            packed_v[pass] = 24'h0;
            for (int k = 0; k < 8; k++) packed_v[pass][3*k +: 3] = f[k];
        end
        l = packed_v[0];
        r = packed_v[1];
    endtask

    task automatic model_steps(input int n);
        for (int s = 0; s < n; s++) m_lfsr = lfsr_step(m_lfsr);
    endtask

    function automatic bit all_distinct(input logic [23:0] v);
        logic [7:0] seen;
        seen = 8'h00;
        for (int k = 0; k < 8; k++) seen[v[3*k +: 3]] = 1'b1;
        return seen == 8'hFF;
    endfunction

    // Counts falling-edge samples with busy high, bounded.
    task automatic gen_wait(input string tag, input int want);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            cycle();
        end
        check(tag, 32'(n), 32'(want));
    endtask

    task automatic commit(input string tag);
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        exp_fc++;
        check({tag, "_key_l"}, 32'(current_key_l), 32'(exp_l));
        check({tag, "_key_r"}, 32'(current_key_r), 32'(exp_r));
        check({tag, "_valid"}, 32'(key_valid), 32'd1);
        check({tag, "_fcnt"},  32'(frame_count), 32'(exp_fc));
        check({tag, "_busy"},  32'(busy), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_key_l"}, 32'(current_key_l), 32'd0);
        check({tag, "_key_r"}, 32'(current_key_r), 32'd0);
        check({tag, "_valid"}, 32'(key_valid), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_fcnt"},  32'(frame_count), 32'd0);
        check({tag, "_ovr"},   32'(overrun_count), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_vec       = 0;
        n_err       = 0;
        bad_perm    = 0;
        reset       = 1'b1;
        enable      = 1'b0;
        frame_start = 1'b0;
        seed_load   = 1'b0;
        seed        = 16'h0000;
        m_lfsr      = 16'hACE1;
        exp_fc      = 16'h0000;
        exp_ovr     = 8'h00;

        // Reset state, then idle with enable low.
        repeat (2) cycle();
        check_reset_state("reset");
        reset = 1'b0;
        cycle();
        check("idle_busy", 32'(busy), 32'd0);

        // First enable: exactly 14 busy cycles, keys stay zero until a commit.
        enable = 1'b1;
        cycle();
        model_gen(exp_l, exp_r);
        first_l = exp_l;
        first_r = exp_r;
        gen_wait("gen_first_len", 14);
        check("ready_key_l", 32'(current_key_l), 32'd0);
        check("ready_valid", 32'(key_valid), 32'd0);
        repeat (3) cycle();
        check("ready_hold_key_r", 32'(current_key_r), 32'd0);
        check("ready_hold_busy",  32'(busy), 32'd0);

        // First commit against the 0xACE1-seeded model.
        commit("commit1");
        model_gen(exp_l, exp_r);

        // frame_start five cycles after the commit lands mid-generation.
        repeat (4) cycle();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
        exp_ovr = exp_ovr + OVR_STEP;
        check("ovr_key_l", 32'(current_key_l), 32'(first_l));
        check("ovr_key_r", 32'(current_key_r), 32'(first_r));
        check("ovr_fcnt",  32'(frame_count), 32'(exp_fc));
        check("ovr_count", 32'(overrun_count), 32'(exp_ovr));
        gen_wait("gen_after_ovr_len", 9);

        // seed_load with seed 0 beats a simultaneous frame_start in READY.
        seed        = 16'h0000;
        seed_load   = 1'b1;
        frame_start = 1'b1;
        cycle();
        seed_load   = 1'b0;
        frame_start = 1'b0;
        check("seed_key_l", 32'(current_key_l), 32'd0);
        check("seed_key_r", 32'(current_key_r), 32'd0);
        check("seed_valid", 32'(key_valid), 32'd0);
        check("seed_fcnt",  32'(frame_count), 32'(exp_fc));
        check("seed_ovr",   32'(overrun_count), 32'(exp_ovr));
        check("seed_busy",  32'(busy), 32'd1);
        m_lfsr = 16'hACE1;
        model_gen(exp_l, exp_r);
        gen_wait("gen_seed_len", 14);
        // Keys after this commit prove the LFSR restarted at 0xACE1.
        commit("commit_seed");

        // Drop enable on the 10th edge after the commit (inside GEN_R):
        // 9 swap steps have consumed LFSR values by then.
        repeat (9) cycle();
        check("pre_drop_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        cycle();
        model_steps(9);
        check("drop_busy",  32'(busy), 32'd0);
        check("drop_key_l", 32'(current_key_l), 32'd0);
        check("drop_key_r", 32'(current_key_r), 32'd0);
        check("drop_valid", 32'(key_valid), 32'd0);
        check("drop_fcnt",  32'(frame_count), 32'(exp_fc));
        cycle();
        check("drop_idle_busy", 32'(busy), 32'd0);

        // Re-enable: a fresh 14-cycle pass from the retained LFSR.
        enable = 1'b1;
        cycle();
        model_gen(exp_l, exp_r);
        gen_wait("gen_regen_len", 14);
        commit("commit_regen");

        // Reset mid-generation abandons the pass and clears everything.
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        check_reset_state("midgen_reset");
        reset   = 1'b0;
        m_lfsr  = 16'hACE1;
        exp_fc  = 16'h0000;
        exp_ovr = 8'h00;
        cycle();
        model_gen(exp_l, exp_r);
        gen_wait("gen_post_reset_len", 14);

        // Long run of periodic frames.
        for (int f = 0; f < FRAMES; f++) begin
            frame_start = 1'b1;
            cycle();
            frame_start = 1'b0;
            exp_fc++;
            check("run_key_l", 32'(current_key_l), 32'(exp_l));
            check("run_key_r", 32'(current_key_r), 32'(exp_r));
            if (!all_distinct(current_key_l) || !all_distinct(current_key_r)) bad_perm++;
            model_gen(exp_l, exp_r);
            repeat (PERIOD - 1) cycle();
        end
        check("run_bad_perms", 32'(bad_perm), 32'd0);
        check("run_fcnt",      32'(frame_count), 32'd1000);
        check("run_ovr",       32'(overrun_count), 32'd0);
        check("run_valid",     32'(key_valid), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
